// File: rtl/visor_breakpoint_supervisor.sv
// visor_breakpoint_supervisor
// Debug supervisor between a synapse316 target's code-fetch port and its
// code ROM. Gates every fetch so a host command port can:
//   - hold the target in reset
//   - halt, resume and single-step it
//   - stop it on address breakpoints
//   - inject instructions while it is halted.
// It also counts accepted ROM fetches.
// Optional build macro: VISOR_FETCH_TRACE_EN adds a circular buffer of
// fetched addresses, read through trace_rd_idx/trace_rd_addr.
module visor_breakpoint_supervisor #(
  parameter int ADDR_WIDTH      = 16,
  parameter int CODE_WIDTH      = 16,
  parameter int NUM_BREAKPOINTS = 4,
  parameter int BP_IDX_WIDTH    = 2,
  parameter int RESET_CYCLES    = 4,
  parameter int BOOT_RUN        = 1,
  parameter int TRACE_DEPTH     = 8,
  localparam int TRACE_IDX_W    = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1
) (
  input  logic                    sysclk,
  input  logic                    sysreset,
  input  logic [CODE_WIDTH-1:0]   rom_code_in,
  input  logic                    rom_code_ready,
  input  logic [ADDR_WIDTH-1:0]   tg_code_addr,
  output logic [CODE_WIDTH-1:0]   tg_code_in,
  output logic                    tg_code_ready,
  output logic                    tg_reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [2:0]              cmd_op,
  input  logic [BP_IDX_WIDTH-1:0] cmd_idx,
  input  logic [CODE_WIDTH-1:0]   cmd_arg,
  output logic                    halted,
  output logic [1:0]              halt_cause,
  output logic [ADDR_WIDTH-1:0]   stop_addr,
  output logic [31:0]             fetch_count,
  input  logic [TRACE_IDX_W-1:0]  trace_rd_idx,
  output logic [ADDR_WIDTH-1:0]   trace_rd_addr
);

  localparam int RST_CNT_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  localparam logic [2:0] OP_HALT         = 3'd0;
  localparam logic [2:0] OP_RUN          = 3'd1;
  localparam logic [2:0] OP_STEP         = 3'd2;
  localparam logic [2:0] OP_SET_BP       = 3'd3;
  localparam logic [2:0] OP_CLR_BP       = 3'd4;
  localparam logic [2:0] OP_INJECT       = 3'd5;
  localparam logic [2:0] OP_RESET_TARGET = 3'd6;
  localparam logic [2:0] OP_RELEASE      = 3'd7;

  localparam logic [1:0] CAUSE_NONE = 2'd0;
  localparam logic [1:0] CAUSE_HOST = 2'd1;
  localparam logic [1:0] CAUSE_BP   = 2'd2;
  localparam logic [1:0] CAUSE_STEP = 2'd3;

  typedef enum logic [2:0] {
    S_RESET_HOLD = 3'd0,
    S_RUN        = 3'd1,
    S_HALTED     = 3'd2,
    S_STEP       = 3'd3,
    S_INJECT     = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [RST_CNT_W-1:0]  r_rst_cnt;
  logic [RST_CNT_W-1:0]  w_rst_cnt_next;
  logic                  r_boot;         // current reset hold came from sysreset
  logic                  w_boot_next;
  logic                  r_skip;         // suppress breakpoints until one ROM fetch completes
  logic                  w_skip_next;
  logic [1:0]            r_halt_cause;
  logic [1:0]            w_halt_cause_next;
  logic [ADDR_WIDTH-1:0] r_stop_addr;
  logic [ADDR_WIDTH-1:0] w_stop_addr_next;
  logic [CODE_WIDTH-1:0] r_inj_code;
  logic [CODE_WIDTH-1:0] w_inj_code_next;
  logic [31:0]           r_fetch_count;

  logic                       w_cmd_acc;
  logic                       w_bp_wr;
  logic                       w_bp_set;
  logic [NUM_BREAKPOINTS-1:0] w_bp_match;
  logic                       w_bp_hit;
  logic                       w_rom_fetch;

  assign w_cmd_acc = cmd_valid & cmd_ready;
  assign w_bp_wr   = w_cmd_acc & ((cmd_op == OP_SET_BP) | (cmd_op == OP_CLR_BP));
  assign w_bp_set  = (cmd_op == OP_SET_BP);
  assign w_bp_hit  = (|w_bp_match) & ~r_skip;

  // Breakpoint comparators. An index with no comparator matches no gi and
  // is therefore silently dropped.
  generate
    for (genvar gi = 0; gi < NUM_BREAKPOINTS; gi++) begin : g_bp
      logic                  r_bp_en;
      logic [ADDR_WIDTH-1:0] r_bp_addr;

      // Enable/address update on an accepted SET_BP/CLR_BP for this slot
      always_ff @(posedge sysclk or posedge sysreset) begin
        if (sysreset) begin
          r_bp_en   <= 1'b0;
          r_bp_addr <= '0;
        end else if (w_bp_wr && (cmd_idx == BP_IDX_WIDTH'(gi))) begin
          r_bp_en <= w_bp_set;
          if (w_bp_set) begin
            r_bp_addr <= cmd_arg[ADDR_WIDTH-1:0];
          end
        end
      end

      assign w_bp_match[gi] = r_bp_en && (r_bp_addr == tg_code_addr);
    end
  endgenerate

  // Next-state, fetch gating and command decode
  always_comb begin
    w_state_next      = r_state;
    w_rst_cnt_next    = r_rst_cnt;
    w_boot_next       = r_boot;
    w_skip_next       = r_skip;
    w_halt_cause_next = r_halt_cause;
    w_stop_addr_next  = r_stop_addr;
    w_inj_code_next   = r_inj_code;
    tg_code_in        = rom_code_in;
    tg_code_ready     = 1'b0;
    tg_reset          = 1'b0;
    cmd_ready         = 1'b0;
    w_rom_fetch       = 1'b0;

    case (r_state)
      S_RESET_HOLD: begin
        tg_reset   = 1'b1;
        tg_code_in = '0;
        if (r_rst_cnt == RST_CNT_W'(RESET_CYCLES - 1)) begin
          w_boot_next = 1'b0;
          if ((BOOT_RUN != 0) && r_boot) begin
            w_state_next = S_RUN;
          end else begin
            w_state_next      = S_HALTED;
            w_halt_cause_next = CAUSE_HOST;
          end
        end else begin
          w_rst_cnt_next = r_rst_cnt + 1'b1;
        end
      end

      S_RUN: begin
        cmd_ready     = 1'b1;
        tg_code_ready = rom_code_ready & ~w_bp_hit;
        w_rom_fetch   = tg_code_ready;
        if (w_rom_fetch) begin
          w_skip_next = 1'b0;
        end
        if (w_cmd_acc && (cmd_op == OP_RESET_TARGET)) begin
          w_state_next      = S_RESET_HOLD;
          w_rst_cnt_next    = '0;
          w_boot_next       = 1'b0;
          w_skip_next       = 1'b0;
          w_halt_cause_next = CAUSE_NONE;
        end else if (w_bp_hit) begin
          w_state_next      = S_HALTED;
          w_halt_cause_next = CAUSE_BP;
          w_stop_addr_next  = tg_code_addr;
        end else if (w_cmd_acc && (cmd_op == OP_HALT)) begin
          // A fetch accepted on this same edge still completes
          w_state_next      = S_HALTED;
          w_halt_cause_next = CAUSE_HOST;
          w_stop_addr_next  = tg_code_addr;
        end
      end

      S_STEP: begin
        tg_code_ready = rom_code_ready & ~w_bp_hit;
        w_rom_fetch   = tg_code_ready;
        if (w_bp_hit) begin
          w_state_next      = S_HALTED;
          w_halt_cause_next = CAUSE_BP;
          w_stop_addr_next  = tg_code_addr;
        end else if (w_rom_fetch) begin
          w_skip_next       = 1'b0;
          w_state_next      = S_HALTED;
          w_halt_cause_next = CAUSE_STEP;
          w_stop_addr_next  = tg_code_addr;
        end
      end

      S_HALTED: begin
        cmd_ready = 1'b1;
        if (w_cmd_acc) begin
          case (cmd_op)
            OP_RUN: begin
              w_state_next      = S_RUN;
              w_skip_next       = 1'b1;
              w_halt_cause_next = CAUSE_NONE;
            end
            OP_STEP: begin
              w_state_next      = S_STEP;
              w_skip_next       = 1'b1;
              w_halt_cause_next = CAUSE_NONE;
            end
            OP_RELEASE: begin
              w_state_next      = S_RUN;
              w_skip_next       = 1'b0;
              w_halt_cause_next = CAUSE_NONE;
            end
            OP_INJECT: begin
              w_state_next    = S_INJECT;
              w_inj_code_next = cmd_arg;
            end
            OP_RESET_TARGET: begin
              w_state_next      = S_RESET_HOLD;
              w_rst_cnt_next    = '0;
              w_boot_next       = 1'b0;
              w_skip_next       = 1'b0;
              w_halt_cause_next = CAUSE_NONE;
            end
            default: ;
          endcase
        end
      end

      S_INJECT: begin
        // One forced fetch; halt cause and stop address are preserved
        tg_code_in    = r_inj_code;
        tg_code_ready = 1'b1;
        w_state_next  = S_HALTED;
      end

      default: begin
        w_state_next   = S_RESET_HOLD;
        w_rst_cnt_next = '0;
      end
    endcase
  end

  // FSM and supervisor status registers
  always_ff @(posedge sysclk or posedge sysreset) begin
    if (sysreset) begin
      r_state      <= S_RESET_HOLD;
      r_rst_cnt    <= '0;
      r_boot       <= 1'b1;
      r_skip       <= 1'b0;
      r_halt_cause <= CAUSE_NONE;
      r_stop_addr  <= '0;
      r_inj_code   <= '0;
    end else begin
      r_state      <= w_state_next;
      r_rst_cnt    <= w_rst_cnt_next;
      r_boot       <= w_boot_next;
      r_skip       <= w_skip_next;
      r_halt_cause <= w_halt_cause_next;
      r_stop_addr  <= w_stop_addr_next;
      r_inj_code   <= w_inj_code_next;
    end
  end

  // Accepted ROM fetch counter; injected fetches and target resets leave it alone
  always_ff @(posedge sysclk or posedge sysreset) begin
    if (sysreset) begin
      r_fetch_count <= '0;
    end else if (w_rom_fetch) begin
      r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

  assign halted      = (r_state == S_HALTED);
  assign halt_cause  = r_halt_cause;
  assign stop_addr   = r_stop_addr;
  assign fetch_count = r_fetch_count;

`ifdef VISOR_FETCH_TRACE_EN
  logic [TRACE_IDX_W-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0]  w_trace [TRACE_DEPTH];
  logic [TRACE_IDX_W-1:0] w_rd_slot;

  // Write pointer advances on every accepted fetch, ROM or injected
  always_ff @(posedge sysclk or posedge sysreset) begin
    if (sysreset) begin
      r_wr_ptr <= '0;
    end else if (tg_code_ready) begin
      r_wr_ptr <= r_wr_ptr + 1'b1;
    end
  end

  // Entries are plain flops so they can be cleared and read combinationally
  generate
    for (genvar gi = 0; gi < TRACE_DEPTH; gi++) begin : g_trace
      logic [ADDR_WIDTH-1:0] r_entry;

      // Capture the fetch address into the slot under the write pointer
      always_ff @(posedge sysclk or posedge sysreset) begin
        if (sysreset) begin
          r_entry <= '0;
        end else if (tg_code_ready && (r_wr_ptr == TRACE_IDX_W'(gi))) begin
          r_entry <= tg_code_addr;
        end
      end

      assign w_trace[gi] = r_entry;
    end
  endgenerate

  // Index 0 is the newest entry, i.e. the slot just behind the write pointer
  assign w_rd_slot     = r_wr_ptr - TRACE_IDX_W'(1) - trace_rd_idx;
  assign trace_rd_addr = w_trace[w_rd_slot];
`else
  logic w_unused_trace_idx;
  assign w_unused_trace_idx = ^trace_rd_idx;
  assign trace_rd_addr      = '0;
`endif

endmodule

// File: tb/tb_visor_breakpoint_supervisor.sv
// tb_visor_breakpoint_supervisor
// Scoreboard bench: a simple target model increments its PC on each
// accepted fetch; expected fetches (address, instruction) are queued as
// stimulus is driven and popped by a monitor whenever tg_code_ready is seen.
module tb_visor_breakpoint_supervisor;

  localparam int AW  = 16;
  localparam int CW  = 16;
  localparam int BPW = 2;
  localparam int TIW = 3;

  localparam logic [2:0] OP_HALT         = 3'd0;
  localparam logic [2:0] OP_RUN          = 3'd1;
  localparam logic [2:0] OP_STEP         = 3'd2;
  localparam logic [2:0] OP_SET_BP       = 3'd3;
  localparam logic [2:0] OP_CLR_BP       = 3'd4;
  localparam logic [2:0] OP_INJECT       = 3'd5;
  localparam logic [2:0] OP_RESET_TARGET = 3'd6;
  localparam logic [2:0] OP_RELEASE      = 3'd7;

  logic           sysclk = 1'b0;
  logic           sysreset = 1'b0;
  logic [CW-1:0]  rom_code_in;
  logic           rom_code_ready = 1'b0;
  logic [AW-1:0]  tg_code_addr;
  logic [CW-1:0]  tg_code_in;
  logic           tg_code_ready;
  logic           tg_reset;
  logic           cmd_valid = 1'b0;
  logic           cmd_ready;
  logic [2:0]     cmd_op = 3'd0;
  logic [BPW-1:0] cmd_idx = '0;
  logic [CW-1:0]  cmd_arg = '0;
  logic           halted;
  logic [1:0]     halt_cause;
  logic [AW-1:0]  stop_addr;
  logic [31:0]    fetch_count;
  logic [TIW-1:0] trace_rd_idx = '0;
  logic [AW-1:0]  trace_rd_addr;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [CW-1:0] code;
  } fetch_t;

  fetch_t sb_q[$];

  logic [AW-1:0] pc = '0;

  visor_breakpoint_supervisor dut (
    .sysclk         (sysclk),
    .sysreset       (sysreset),
    .rom_code_in    (rom_code_in),
    .rom_code_ready (rom_code_ready),
    .tg_code_addr   (tg_code_addr),
    .tg_code_in     (tg_code_in),
    .tg_code_ready  (tg_code_ready),
    .tg_reset       (tg_reset),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_op         (cmd_op),
    .cmd_idx        (cmd_idx),
    .cmd_arg        (cmd_arg),
    .halted         (halted),
    .halt_cause     (halt_cause),
    .stop_addr      (stop_addr),
    .fetch_count    (fetch_count),
    .trace_rd_idx   (trace_rd_idx),
    .trace_rd_addr  (trace_rd_addr)
  );

  always #5 sysclk = ~sysclk;

  function automatic logic [CW-1:0] rom_word(input logic [AW-1:0] a);
    return a ^ 16'h5A3C;
  endfunction

  // Code ROM and target model
  assign rom_code_in  = rom_word(pc);
  assign tg_code_addr = pc;

  always @(posedge sysclk) begin
    if (tg_reset) pc <= '0;
    else if (tg_code_ready) pc <= pc + 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_rom(input int lo, input int hi);
    for (int a = lo; a <= hi; a++) begin
      sb_q.push_back({AW'(a), rom_word(AW'(a))});
    end
  endtask

  task automatic send_cmd(input logic [2:0] op, input logic [BPW-1:0] idx, input logic [CW-1:0] arg);
    @(negedge sysclk);
    cmd_op    = op;
    cmd_idx   = idx;
    cmd_arg   = arg;
    cmd_valid = 1'b1;
    $display("cmd op=%0d idx=%0d arg=0x%04h", op, idx, arg);
    @(negedge sysclk);
    cmd_valid = 1'b0;
  endtask

  task automatic fetch_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge sysclk);
      rom_code_ready = 1'b1;
    end
    @(negedge sysclk);
    rom_code_ready = 1'b0;
  endtask

  task automatic wait_halted(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge sysclk);
      if (halted) break;
    end
    check(tag, 32'(halted), 32'd1);
  endtask

  // Counts edges with tg_reset high, starting from the current negedge
  task automatic count_reset(input string tag);
    int n;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (!tg_reset) break;
      n++;
      @(negedge sysclk);
    end
    check(tag, 32'(n), 32'd4);
  endtask

  // Scoreboard monitor: sample just before the consuming edge
  always @(negedge sysclk) begin
    fetch_t e;
    #2;
    if (!sysreset && tg_code_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_fetch", 32'(sb_q.size()), 32'd1);
      end else begin
        e = sb_q.pop_front();
        check("fetch_addr", 32'(tg_code_addr), 32'(e.addr));
        check("fetch_code", 32'(tg_code_in), 32'(e.code));
        $display("fetch addr=0x%04h code=0x%04h", tg_code_addr, tg_code_in);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    #1 sysreset = 1'b1;

    // Outputs while sysreset is asserted
    @(negedge sysclk);
    check("rst_tg_reset",    32'(tg_reset),      32'd1);
    check("rst_tg_ready",    32'(tg_code_ready), 32'd0);
    check("rst_tg_code_in",  32'(tg_code_in),    32'd0);
    check("rst_cmd_ready",   32'(cmd_ready),     32'd0);
    check("rst_halted",      32'(halted),        32'd0);
    check("rst_halt_cause",  32'(halt_cause),    32'd0);
    check("rst_stop_addr",   32'(stop_addr),     32'd0);
    check("rst_fetch_count", fetch_count,        32'd0);

    // Boot into RUN, 10 fetches with ROM stalls in between
    @(negedge sysclk);
    sysreset = 1'b0;
    count_reset("boot_reset_len");
    check("boot_halted",    32'(halted),    32'd0);
    check("boot_cmd_ready", 32'(cmd_ready), 32'd1);
    push_rom(0, 9);
    k = 0;
    for (int i = 0; i < 40 && k < 10; i++) begin
      @(negedge sysclk);
      rom_code_ready = ((i % 3) != 2);
      if (rom_code_ready) k++;
    end
    @(negedge sysclk);
    rom_code_ready = 1'b0;
    check("boot_fetch_count", fetch_count, 32'd10);
    check("boot_pc", 32'(tg_code_addr), 32'h000A);

`ifdef VISOR_FETCH_TRACE_EN
    trace_rd_idx = 3'd0; #1 check("trace_idx0", 32'(trace_rd_addr), 32'd9);
    trace_rd_idx = 3'd1; #1 check("trace_idx1", 32'(trace_rd_addr), 32'd8);
    trace_rd_idx = 3'd7; #1 check("trace_idx7", 32'(trace_rd_addr), 32'd2);
`else
    trace_rd_idx = 3'd0; #1 check("trace_off_idx0", 32'(trace_rd_addr), 32'd0);
    trace_rd_idx = 3'd5; #1 check("trace_off_idx5", 32'(trace_rd_addr), 32'd0);
`endif

    // Breakpoint at 0x0020 while running
    send_cmd(OP_SET_BP, 2'd1, 16'h0020);
    push_rom(16'h000A, 16'h001F);
    rom_code_ready = 1'b1;
    wait_halted("bp_halt", 100);
    check("bp_tg_ready", 32'(tg_code_ready), 32'd0);
    check("bp_cause",    32'(halt_cause),    32'd2);
    check("bp_stop",     32'(stop_addr),     32'h0020);
    check("bp_pc",       32'(tg_code_addr),  32'h0020);
    check("bp_drain",    32'(sb_q.size()),   32'd0);
    rom_code_ready = 1'b0;

    // Resume: the breakpointed address executes once, then continues
    push_rom(16'h0020, 16'h0027);
    send_cmd(OP_RUN, 2'd0, 16'h0000);
    fetch_cycles(8);
    check("resume_pc",     32'(tg_code_addr), 32'h0028);
    check("resume_drain",  32'(sb_q.size()),  32'd0);
    check("resume_fcount", fetch_count,       32'd40);

    // STEP is illegal in RUN and must be ignored
    send_cmd(OP_STEP, 2'd0, 16'h0000);
    check("step_in_run_halted",    32'(halted),    32'd0);
    check("step_in_run_cmd_ready", 32'(cmd_ready), 32'd1);

    // Host HALT, then three single steps
    send_cmd(OP_HALT, 2'd0, 16'h0000);
    check("halt_halted", 32'(halted),     32'd1);
    check("halt_cause",  32'(halt_cause), 32'd1);
    check("halt_stop",   32'(stop_addr),  32'h0028);
    for (int s = 0; s < 3; s++) begin
      push_rom(16'h0028 + s, 16'h0028 + s);
      rom_code_ready = 1'b1;
      send_cmd(OP_STEP, 2'd0, 16'h0000);
      wait_halted("step_halt", 10);
      check("step_cause", 32'(halt_cause), 32'd3);
      check("step_stop",  32'(stop_addr),  32'h0028 + 32'(s));
    end
    rom_code_ready = 1'b0;
    check("step_fcount", fetch_count,      32'd43);
    check("step_drain",  32'(sb_q.size()), 32'd0);

    // HALT while halted is ignored
    send_cmd(OP_HALT, 2'd0, 16'h0000);
    check("halt_in_halted_cause", 32'(halt_cause), 32'd3);

    // Instruction injection
    sb_q.push_back({16'h002B, 16'h1234});
    @(negedge sysclk);
    cmd_op    = OP_INJECT;
    cmd_arg   = 16'h1234;
    cmd_valid = 1'b1;
    $display("cmd op=%0d idx=%0d arg=0x%04h", OP_INJECT, 0, 16'h1234);
    @(negedge sysclk);
    cmd_valid = 1'b0;
    check("inj_tg_ready",  32'(tg_code_ready), 32'd1);
    check("inj_code",      32'(tg_code_in),    32'h1234);
    check("inj_cmd_ready", 32'(cmd_ready),     32'd0);
    check("inj_halted",    32'(halted),        32'd0);
    @(negedge sysclk);
    check("inj_back_halted", 32'(halted),     32'd1);
    check("inj_cause",       32'(halt_cause), 32'd3);
    check("inj_stop",        32'(stop_addr),  32'h002A);
    check("inj_fcount",      fetch_count,     32'd43);
    check("inj_drain",       32'(sb_q.size()), 32'd0);

    // RELEASE does not skip a breakpoint at the current address
    send_cmd(OP_SET_BP, 2'd0, 16'h002C);
    rom_code_ready = 1'b1;
    send_cmd(OP_RELEASE, 2'd0, 16'h0000);
    wait_halted("release_halt", 10);
    check("release_cause", 32'(halt_cause), 32'd2);
    check("release_stop",  32'(stop_addr),  32'h002C);
    rom_code_ready = 1'b0;

    push_rom(16'h002C, 16'h002D);
    send_cmd(OP_RUN, 2'd0, 16'h0000);
    fetch_cycles(2);
    check("run2_pc", 32'(tg_code_addr), 32'h002E);

    // RESET_TARGET while running: breakpoints and fetch count survive
    send_cmd(OP_RESET_TARGET, 2'd0, 16'h0000);
    count_reset("tgt_reset_len");
    check("tgt_halted", 32'(halted),       32'd1);
    check("tgt_cause",  32'(halt_cause),   32'd1);
    check("tgt_fcount", fetch_count,       32'd45);
    check("tgt_pc",     32'(tg_code_addr), 32'd0);

    send_cmd(OP_CLR_BP, 2'd1, 16'h0000);
    push_rom(0, 16'h002B);
    rom_code_ready = 1'b1;
    send_cmd(OP_RUN, 2'd0, 16'h0000);
    wait_halted("bp0_halt", 100);
    check("bp0_cause",  32'(halt_cause),   32'd2);
    check("bp0_stop",   32'(stop_addr),    32'h002C);
    check("bp0_drain",  32'(sb_q.size()),  32'd0);
    check("bp0_fcount", fetch_count,       32'd89);
    rom_code_ready = 1'b0;

    repeat (3) @(negedge sysclk);
    check("final_drain", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
